jelly_fifo_ra_write_ctl: RTL

Write-side controller of the random-access FIFO; the producer-end counterpart to the FWFT random-access read side. It accepts (offset, data) beats addressed relative to the current write pointer, issues RAM writes only into free space, and publishes completed data to the reader through explicit commit transactions that advance the write pointer. It sits between a producer that fills slots out of order (reorder, scatter) and the dual-port RAM plus read-side pointer logic.

---
 rtl/jelly_fifo_ra_write_ctl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/jelly_fifo_ra_write_ctl.sv
// Write-side controller of the random-access FIFO: offset-addressed beats are written only
// into released space, and explicit commits publish them by advancing the write pointer.
module jelly_fifo_ra_write_ctl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int PTR_WIDTH  = ADDR_WIDTH + 1,
   parameter int SLAVE_REGS = 1
) (
   input  logic                  reset,
   input  logic                  clk,

   input  logic [ADDR_WIDTH-1:0] s_addr,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,

   input  logic [PTR_WIDTH-1:0]  s_commit_size,
   input  logic                  s_commit_valid,
   output logic                  s_commit_ready,

   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,

   input  logic [PTR_WIDTH-1:0]  rd_ptr,
   output logic [PTR_WIDTH-1:0]  wr_ptr,
   output logic [PTR_WIDTH-1:0]  free_count
);

   localparam logic [PTR_WIDTH-1:0] DEPTH = PTR_WIDTH'(1) << ADDR_WIDTH;

   logic [PTR_WIDTH-1:0]  wr_ptr_reg;
   logic                  st_valid_reg;
   logic [ADDR_WIDTH-1:0] st_addr_reg;
   logic [DATA_WIDTH-1:0] st_data_reg;

   logic                  write_go;
   logic                  stage_load;
   logic                  in_valid;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  skid_empty;

   // Occupancy is taken modulo 2^PTR_WIDTH so the wrap bit keeps full and empty distinct.
   assign free_count = DEPTH - (wr_ptr_reg - rd_ptr);
   assign wr_ptr     = wr_ptr_reg;

   assign write_go   = st_valid_reg && (PTR_WIDTH'(st_addr_reg) < free_count);
   assign stage_load = !st_valid_reg || write_go;

   assign wr_en   = write_go;
   assign wr_addr = write_go ? (wr_ptr_reg[ADDR_WIDTH-1:0] + st_addr_reg) : '0;
   assign wr_data = write_go ? st_data_reg : '0;

   generate
      if (SLAVE_REGS != 0) begin : g_skid
         logic                  skid_valid_reg;
         logic                  skid_valid_next;
         logic [ADDR_WIDTH-1:0] skid_addr_reg;
         logic [DATA_WIDTH-1:0] skid_data_reg;
         logic                  s_ready_reg;
         logic                  s_accept;

         assign s_accept = s_valid && s_ready_reg;

         // The skid only fills while the stage is held, so it always drains into the stage first.
         always_comb begin
            skid_valid_next = skid_valid_reg;
            if (stage_load) begin
               skid_valid_next = 1'b0;
            end else if (s_accept) begin
               skid_valid_next = 1'b1;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               skid_valid_reg <= 1'b0;
               skid_addr_reg  <= '0;
               skid_data_reg  <= '0;
               s_ready_reg    <= 1'b1;
            end else begin
               skid_valid_reg <= skid_valid_next;
               s_ready_reg    <= !skid_valid_next;
               if (!stage_load && s_accept) begin
                  skid_addr_reg <= s_addr;
                  skid_data_reg <= s_data;
               end
            end
         end

         assign s_ready    = s_ready_reg;
         assign skid_empty = !skid_valid_reg;
         assign in_valid   = skid_valid_reg || s_accept;
         assign in_addr    = skid_valid_reg ? skid_addr_reg : s_addr;
         assign in_data    = skid_valid_reg ? skid_data_reg : s_data;
      end else begin : g_direct
         assign s_ready    = stage_load;
         assign skid_empty = 1'b1;
         assign in_valid   = s_valid;
         assign in_addr    = s_addr;
         assign in_data    = s_data;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_valid_reg <= 1'b0;
         st_addr_reg  <= '0;
         st_data_reg  <= '0;
      end else if (stage_load) begin
         st_valid_reg <= in_valid;
         if (in_valid) begin
            st_addr_reg <= in_addr;
            st_data_reg <= in_data;
         end
      end
   end

   // Commits wait for an empty write path so published slots already hold their data.
   assign s_commit_ready = !st_valid_reg && skid_empty && (s_commit_size <= free_count);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
      end else if (s_commit_valid && s_commit_ready) begin
         wr_ptr_reg <= wr_ptr_reg + s_commit_size;
      end
   end

endmodule
